// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   - state_t: controller FSM states
//   - opcode / funct codes the controller recognises
//   - ALU operation encodings (3-bit)
//   - select codes for regdst, memtoreg, alusrcb and pcsrc
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Register-file destination select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that own the memory port and are subject to the watchdog
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_aludec.sv
// R-type ALU decoder.
//   funct      in  6  instr[5:0]
//   alucontrol out 3  ALU operation for the R-type execute cycle
//   legal      out 1  funct is one of add/sub/and/or/slt
module mips_aludec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       legal
);

  always_comb begin
    alucontrol = ALU_ADD;
    legal      = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Multicycle MIPS control unit (Moore FSM) over a shared datapath and a single
// instruction+data memory port with a req/rdy handshake.
//   clk, reset (async, active-low)
//   op, funct, zero, mem_rdy                         : inputs from IR, ALU, memory
//   mem_req, memwrite, iord                          : memory port control
//   irwrite, pcen, regwrite, regdst, memtoreg        : state-element enables/selects
//   alusrca, alusrcb, pcsrc, alucontrol              : datapath steering
//   trap, trap_cause                                 : sticky trap flag and cause
//                                                      (0 illegal instr, 1 mem timeout)
module mips_multi_ctrl
  import mips_pkg::*;
#(
  parameter int ALUCW   = 3,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             mem_req,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcen,
  output logic             regwrite,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [ALUCW-1:0] alucontrol,
  output logic             trap,
  output logic             trap_cause
);

  state_t           state, state_next;
  logic [TMO_W-1:0] wdog;
  logic             wdog_expired;
  logic             trap_q, cause_q;
  logic             cause_next;
  logic [2:0]       alu_rtype;
  logic             funct_legal;
  logic [2:0]       alu_sel;

  mips_aludec u_aludec (
    .funct      (funct),
    .alucontrol (alu_rtype),
    .legal      (funct_legal)
  );

  // A completing access in the limit cycle takes priority over the timeout.
  assign wdog_expired = (wdog == TMO_W'(TMO_MAX)) && !mem_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      wdog    <= '0;
      trap_q  <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      state <= state_next;
      // Count only while stalled in the same memory state; any completion or
      // exit restarts the count for the next access.
      if (is_mem_wait_state(state) && !mem_rdy && (state_next == state))
        wdog <= wdog + TMO_W'(1);
      else
        wdog <= '0;
      if ((state_next == S_TRAP) && (state != S_TRAP)) begin
        trap_q  <= 1'b1;
        cause_q <= cause_next;
      end
    end
  end

  always_comb begin
    state_next = state;
    cause_next = 1'b0;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = REGDST_RT;
    memtoreg   = MTR_ALUOUT;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    pcsrc      = PCSRC_ALU;
    alu_sel    = ALU_ADD;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        if (mem_rdy) begin
          // IR load and PC+4 update share the completing cycle.
          irwrite    = 1'b1;
          pcen       = 1'b1;
          state_next = S_DECODE;
        end else if (wdog_expired) begin
          cause_next = 1'b1;
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_RTYPE:     state_next = funct_legal ? S_RTYPE : S_TRAP;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_rdy) begin
          state_next = S_MEMWB;
        end else if (wdog_expired) begin
          cause_next = 1'b1;
          state_next = S_TRAP;
        end
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        regdst     = REGDST_RT;
        memtoreg   = MTR_MDR;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_rdy) begin
          state_next = S_FETCH;
        end else if (wdog_expired) begin
          cause_next = 1'b1;
          state_next = S_TRAP;
        end
      end
      S_RTYPE: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_RT;
        alu_sel    = alu_rtype;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        regdst     = REGDST_RD;
        memtoreg   = MTR_ALUOUT;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_RT;
        alu_sel    = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen       = zero;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        regdst     = REGDST_RT;
        memtoreg   = MTR_ALUOUT;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = PCSRC_JUMP;
        pcen       = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from fetch, so it is the link value.
        regwrite   = 1'b1;
        regdst     = REGDST_RA;
        memtoreg   = MTR_PC;
        pcsrc      = PCSRC_JUMP;
        pcen       = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // While reset is held every enable is forced off so an in-flight memory
    // request is withdrawn immediately, not at the next clock edge.
    if (!reset) begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      regdst   = REGDST_RT;
      memtoreg = MTR_ALUOUT;
      alusrca  = 1'b0;
      alusrcb  = SRCB_RT;
      pcsrc    = PCSRC_ALU;
      alu_sel  = ALU_ADD;
    end
  end

  assign alucontrol = ALUCW'(alu_sel);
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Directed bench for mips_multi_ctrl (watchdog limit set to 4 wait cycles).
module tb_mips_multi_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_rdy;
  logic       mem_req, memwrite, iord, irwrite, pcen, regwrite;
  logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
  logic       alusrca;
  logic [2:0] alucontrol;
  logic       trap, trap_cause;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  mips_multi_ctrl #(.ALUCW(3), .TMO_W(8), .TMO_MAX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  // {mem_req,memwrite,iord,irwrite,pcen,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,alucontrol}
  logic [17:0] ctrl;
  assign ctrl = {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
                 alusrca, alusrcb, pcsrc, alucontrol};

  localparam logic [17:0] V_IDLE       = {6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010};
  localparam logic [17:0] V_FETCH_WAIT = {6'b100000, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 3'b010};
  localparam logic [17:0] V_FETCH_DONE = {6'b100110, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 3'b010};
  localparam logic [17:0] V_DECODE     = {6'b000000, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 3'b010};
  localparam logic [17:0] V_MEMADR     = {6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 3'b010};
  localparam logic [17:0] V_MEMRD      = {6'b101000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010};
  localparam logic [17:0] V_MEMWB      = {6'b000001, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 3'b010};
  localparam logic [17:0] V_MEMWR      = {6'b111000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010};
  localparam logic [17:0] V_RT_SUB     = {6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b110};
  localparam logic [17:0] V_RT_SLT     = {6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b111};
  localparam logic [17:0] V_ALUWB      = {6'b000001, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010};
  localparam logic [17:0] V_BEQ_T      = {6'b000010, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 3'b110};
  localparam logic [17:0] V_BEQ_N      = {6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 3'b110};
  localparam logic [17:0] V_ADDIEX     = {6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 3'b010};
  localparam logic [17:0] V_ADDIWB     = {6'b000001, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010};
  localparam logic [17:0] V_JUMP       = {6'b000010, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 3'b010};
  localparam logic [17:0] V_JAL        = {6'b000011, 2'b10, 2'b10, 1'b0, 2'b00, 2'b10, 3'b010};

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Advance to 2 ns after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0; mem_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk ("reset_ctrl", ctrl, V_IDLE);
    chk1("reset_trap", trap, 1'b0);
    chk1("reset_cause", trap_cause, 1'b0);

    // Fetch with three wait cycles, completing on the fourth
    reset = 1'b1; #1;
    chk("fetch_wait1", ctrl, V_FETCH_WAIT);
    nxt(); #1; chk("fetch_wait2", ctrl, V_FETCH_WAIT);
    nxt(); #1; chk("fetch_wait3", ctrl, V_FETCH_WAIT);
    nxt(); mem_rdy = 1'b1; op = 6'b100011; #1;
    chk("fetch_done4", ctrl, V_FETCH_DONE);

    // lw: DECODE, MEMADR, MEMRD, MEMWB
    nxt(); #1; chk("lw_decode", ctrl, V_DECODE);
    nxt(); #1; chk("lw_memadr", ctrl, V_MEMADR);
    nxt(); #1; chk("lw_memrd", ctrl, V_MEMRD);
    nxt(); #1; chk("lw_memwb", ctrl, V_MEMWB);
    nxt(); #1; chk("lw_cpi_fetch", ctrl, V_FETCH_DONE);

    // beq taken
    op = 6'b000100; zero = 1'b1;
    nxt(); nxt(); #1; chk("beq_taken", ctrl, V_BEQ_T);
    nxt(); #1; chk("beq_t_cpi", ctrl, V_FETCH_DONE);
    // beq not taken
    zero = 1'b0;
    nxt(); nxt(); #1; chk("beq_not_taken", ctrl, V_BEQ_N);
    nxt(); #1; chk("beq_n_cpi", ctrl, V_FETCH_DONE);

    // jal
    op = 6'b000011;
    nxt(); nxt(); #1; chk("jal", ctrl, V_JAL);
    nxt(); #1; chk("jal_cpi", ctrl, V_FETCH_DONE);

    // R-type sub and slt
    op = 6'b000000; funct = 6'b100010;
    nxt(); nxt(); #1; chk("rtype_sub", ctrl, V_RT_SUB);
    nxt(); #1; chk("aluwb_sub", ctrl, V_ALUWB);
    nxt(); funct = 6'b101010;
    nxt(); nxt(); #1; chk("rtype_slt", ctrl, V_RT_SLT);
    nxt(); #1; chk("aluwb_slt", ctrl, V_ALUWB);

    // addi
    nxt(); op = 6'b001000;
    nxt(); nxt(); #1; chk("addi_ex", ctrl, V_ADDIEX);
    nxt(); #1; chk("addi_wb", ctrl, V_ADDIWB);

    // sw with one write wait state
    nxt(); op = 6'b101011;
    nxt(); nxt(); #1; chk("sw_memadr", ctrl, V_MEMADR);
    nxt(); mem_rdy = 1'b0; #1; chk("sw_memwr_wait", ctrl, V_MEMWR);
    nxt(); mem_rdy = 1'b1; #1; chk("sw_memwr_done", ctrl, V_MEMWR);
    nxt(); #1; chk("sw_back_fetch", ctrl, V_FETCH_DONE);

    // Reset asserted in the middle of a load access
    op = 6'b100011;
    nxt(); nxt(); nxt(); mem_rdy = 1'b0; #1;
    chk("midrd_memrd", ctrl, V_MEMRD);
    reset = 1'b0; #1;
    chk("midrd_req_drop", ctrl, V_IDLE);
    #2; reset = 1'b1;
    nxt(); #1;
    chk ("midrd_fetch", ctrl, V_FETCH_WAIT);
    chk1("midrd_trap", trap, 1'b0);

    // Illegal opcode
    mem_rdy = 1'b1; op = 6'b111111; #1;
    nxt(); nxt(); #1;
    chk ("illop_ctrl", ctrl, V_IDLE);
    chk1("illop_trap", trap, 1'b1);
    chk1("illop_cause", trap_cause, 1'b0);
    nxt(); #1;
    chk1("illop_sticky", trap, 1'b1);

    // Illegal R-type funct
    reset = 1'b0; #1;
    chk1("rst_clears_trap", trap, 1'b0);
    reset = 1'b1; op = 6'b000000; funct = 6'b000111;
    nxt(); nxt(); #1;
    chk1("illfn_trap", trap, 1'b1);
    chk1("illfn_cause", trap_cause, 1'b0);

    // Memory timeout: wdog reaches 4 during the fifth stalled fetch cycle
    mem_rdy = 1'b0; reset = 1'b0; #1; reset = 1'b1;
    repeat (4) nxt();
    #1;
    chk ("tmo_limit_cycle", ctrl, V_FETCH_WAIT);
    chk1("tmo_not_yet", trap, 1'b0);
    nxt(); #1;
    chk1("tmo_trap", trap, 1'b1);
    chk1("tmo_cause", trap_cause, 1'b1);
    chk ("tmo_req_drop", ctrl, V_IDLE);
    nxt(); #1;
    chk1("tmo_req_stays_low", mem_req, 1'b0);

    // mem_rdy in the limit cycle completes the fetch instead of trapping
    reset = 1'b0; #1; reset = 1'b1;
    repeat (4) nxt();
    mem_rdy = 1'b1; op = 6'b000010; #1;
    chk("limit_rdy_wins", ctrl, V_FETCH_DONE);
    nxt(); #1;
    chk ("limit_decode", ctrl, V_DECODE);
    chk1("limit_no_trap", trap, 1'b0);
    nxt(); #1;
    chk("jump", ctrl, V_JUMP);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
